// File: rtl/memory_arbiter.sv
// Round-robin arbiter that funnels four cache request ports onto one memory port.
// Writes trigger a one-cycle invalidate broadcast to every cache except the writer.
module memory_arbiter #(
    parameter int NUM_CACHES = 4,
    parameter int RR_RESET   = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CACHES*33-1:0]   cache_request,
    input  logic [NUM_CACHES-1:0]      cache_request_ready,
    output logic [15:0]                cache_response,
    output logic [NUM_CACHES-1:0]      cache_response_ready,
    output logic [15:0]                invalidate_address,
    output logic [NUM_CACHES-1:0]      invalidate_valid,
    output logic [32:0]                mem_request,
    output logic                       mem_request_ready,
    input  logic [15:0]                mem_response,
    input  logic                       mem_response_ready,
    output logic                       busy
);

    localparam int PTR_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam int REQ_W = 33;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic [PTR_W-1:0]        w_rr_ptr_next;
    logic [PTR_W-1:0]        r_grant;
    logic [PTR_W-1:0]        w_grant_next;
    logic [REQ_W-1:0]        r_grant_req;
    logic [REQ_W-1:0]        w_grant_req_next;

    logic [REQ_W-1:0]        r_mem_request;
    logic [REQ_W-1:0]        w_mem_request_next;
    logic                    r_mem_request_ready;
    logic                    w_mem_request_ready_next;
    logic [15:0]             r_cache_response;
    logic [15:0]             w_cache_response_next;
    logic [NUM_CACHES-1:0]   r_cache_response_ready;
    logic [NUM_CACHES-1:0]   w_cache_response_ready_next;
    logic [15:0]             r_invalidate_address;
    logic [15:0]             w_invalidate_address_next;
    logic [NUM_CACHES-1:0]   r_invalidate_valid;
    logic [NUM_CACHES-1:0]   w_invalidate_valid_next;
    logic                    r_busy;
    logic                    w_busy_next;

    logic [REQ_W-1:0]        w_req_arr   [NUM_CACHES];
    logic [PTR_W-1:0]        w_rot_idx   [NUM_CACHES];
    logic [NUM_CACHES-1:0]   w_rot_ready;
    logic                    w_found;
    logic [PTR_W-1:0]        w_winner;
    logic [NUM_CACHES-1:0]   w_grant_onehot;

    // Rotate the ready vector so that position 0 is the current round-robin head.
    generate
        for (genvar gi = 0; gi < NUM_CACHES; gi++) begin : g_port
            localparam logic [PTR_W-1:0] OFF = PTR_W'(gi);
            assign w_req_arr[gi]   = cache_request[gi*REQ_W +: REQ_W];
            assign w_rot_idx[gi]   = r_rr_ptr + OFF;
            assign w_rot_ready[gi] = cache_request_ready[w_rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (!w_found && w_rot_ready[i]) begin
                w_found  = 1'b1;
                w_winner = w_rot_idx[i];
            end
        end
    end

    assign w_grant_onehot = NUM_CACHES'(1) << r_grant;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state                <= IDLE;
            r_rr_ptr               <= PTR_W'(RR_RESET);
            r_grant                <= '0;
            r_grant_req            <= '0;
            r_mem_request          <= '0;
            r_mem_request_ready    <= 1'b0;
            r_cache_response       <= '0;
            r_cache_response_ready <= '0;
            r_invalidate_address   <= '0;
            r_invalidate_valid     <= '0;
            r_busy                 <= 1'b0;
        end else begin
            r_state                <= w_state_next;
            r_rr_ptr               <= w_rr_ptr_next;
            r_grant                <= w_grant_next;
            r_grant_req            <= w_grant_req_next;
            r_mem_request          <= w_mem_request_next;
            r_mem_request_ready    <= w_mem_request_ready_next;
            r_cache_response       <= w_cache_response_next;
            r_cache_response_ready <= w_cache_response_ready_next;
            r_invalidate_address   <= w_invalidate_address_next;
            r_invalidate_valid     <= w_invalidate_valid_next;
            r_busy                 <= w_busy_next;
        end
    end

    // Strobes default low every cycle; only cache_response and the grant state hold.
    always_comb begin
        w_state_next                = r_state;
        w_rr_ptr_next               = r_rr_ptr;
        w_grant_next                = r_grant;
        w_grant_req_next            = r_grant_req;
        w_mem_request_next          = '0;
        w_mem_request_ready_next    = 1'b0;
        w_cache_response_next       = r_cache_response;
        w_cache_response_ready_next = '0;
        w_invalidate_address_next   = '0;
        w_invalidate_valid_next     = '0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_next             = w_winner;
                    w_grant_req_next         = w_req_arr[w_winner];
                    w_mem_request_next       = w_req_arr[w_winner];
                    w_mem_request_ready_next = 1'b1;
                    w_state_next             = WAIT;
                end
            end
            WAIT: begin
                if (mem_response_ready) begin
                    w_cache_response_next       = mem_response;
                    w_cache_response_ready_next = w_grant_onehot;
                    if (r_grant_req[32]) begin
                        w_invalidate_address_next = r_grant_req[15:0];
                        w_invalidate_valid_next   = ~w_grant_onehot;
                    end
                    w_state_next = RESPOND;
                end else begin
                    w_mem_request_next       = r_grant_req;
                    w_mem_request_ready_next = 1'b1;
                end
            end
            RESPOND: begin
                w_state_next = DRAIN;
            end
            DRAIN: begin
                w_rr_ptr_next = r_grant + PTR_W'(1);
                w_state_next  = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    assign cache_response       = r_cache_response;
    assign cache_response_ready = r_cache_response_ready;
    assign invalidate_address   = r_invalidate_address;
    assign invalidate_valid     = r_invalidate_valid;
    assign mem_request          = r_mem_request;
    assign mem_request_ready    = r_mem_request_ready;
    assign busy                 = r_busy;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter: each table row is one served
// transaction; hand-written sequences cover reset behaviour around a transaction.
module tb_memory_arbiter;

    logic         clock;
    logic         reset;
    logic [131:0] cache_request;
    logic [3:0]   cache_request_ready;
    logic [15:0]  cache_response;
    logic [3:0]   cache_response_ready;
    logic [15:0]  invalidate_address;
    logic [3:0]   invalidate_valid;
    logic [32:0]  mem_request;
    logic         mem_request_ready;
    logic [15:0]  mem_response;
    logic         mem_response_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    memory_arbiter #(.NUM_CACHES(4), .RR_RESET(0)) dut (
        .clock                (clock),
        .reset                (reset),
        .cache_request        (cache_request),
        .cache_request_ready  (cache_request_ready),
        .cache_response       (cache_response),
        .cache_response_ready (cache_response_ready),
        .invalidate_address   (invalidate_address),
        .invalidate_valid     (invalidate_valid),
        .mem_request          (mem_request),
        .mem_request_ready    (mem_request_ready),
        .mem_response         (mem_response),
        .mem_response_ready   (mem_response_ready),
        .busy                 (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          do_reset;
        logic [3:0]  set_ready;
        logic [3:0][32:0] reqs;
        int          lat;
        logic [15:0] rsp;
        logic [3:0]  exp_resp_ready;
        logic [3:0]  exp_inv_valid;
        logic [15:0] exp_inv_addr;
        logic [32:0] exp_mem_req;
    } vec_t;

    localparam int NUM_V = 11;
    vec_t vecs [NUM_V];
    vec_t t;

    function automatic logic [32:0] rq(input logic w, input logic [15:0] d, input logic [15:0] a);
        return {w, d, a};
    endfunction

    function automatic vec_t mkv(input bit rst, input logic [3:0] set,
                                 input logic [32:0] r3, input logic [32:0] r2,
                                 input logic [32:0] r1, input logic [32:0] r0,
                                 input int lat, input logic [15:0] rsp,
                                 input logic [3:0] er, input logic [3:0] ei,
                                 input logic [15:0] ea, input logic [32:0] em);
        vec_t v;
        v.do_reset       = rst;
        v.set_ready      = set;
        v.reqs[3]        = r3;
        v.reqs[2]        = r2;
        v.reqs[1]        = r1;
        v.reqs[0]        = r0;
        v.lat            = lat;
        v.rsp            = rsp;
        v.exp_resp_ready = er;
        v.exp_inv_valid  = ei;
        v.exp_inv_addr   = ea;
        v.exp_mem_req    = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    int n;
    int g;

    initial begin
        // Single read, write-invalidate, rotation after reset, fairness between 0 and 3.
        vecs[0]  = mkv(0, 4'b0100, '0, rq(0, 16'h0000, 16'h1234), '0, '0,
                       3, 16'hBEEF, 4'b0100, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h1234));
        vecs[1]  = mkv(0, 4'b0010, '0, '0, rq(1, 16'hAAAA, 16'h00F0), '0,
                       1, 16'h5A5A, 4'b0010, 4'b1101, 16'h00F0, rq(1, 16'hAAAA, 16'h00F0));
        vecs[2]  = mkv(1, 4'b1111, rq(1, 16'h3333, 16'h0103), rq(0, 16'h0000, 16'h0102),
                       rq(1, 16'h1111, 16'h0101), rq(0, 16'h0000, 16'h0100),
                       2, 16'h0A00, 4'b0001, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h0100));
        vecs[3]  = mkv(0, 4'b0000, '0, '0, '0, '0,
                       0, 16'h0A01, 4'b0010, 4'b1101, 16'h0101, rq(1, 16'h1111, 16'h0101));
        vecs[4]  = mkv(0, 4'b0000, '0, '0, '0, '0,
                       1, 16'h0A02, 4'b0100, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h0102));
        vecs[5]  = mkv(0, 4'b0000, '0, '0, '0, '0,
                       0, 16'h0A03, 4'b1000, 4'b0111, 16'h0103, rq(1, 16'h3333, 16'h0103));
        vecs[6]  = mkv(0, 4'b0001, '0, '0, '0, rq(0, 16'h0000, 16'h0200),
                       1, 16'h0B00, 4'b0001, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h0200));
        vecs[7]  = mkv(0, 4'b1001, rq(0, 16'h0000, 16'h0303), '0, '0, rq(0, 16'h0000, 16'h0300),
                       1, 16'h0C03, 4'b1000, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h0303));
        vecs[8]  = mkv(0, 4'b1000, rq(0, 16'h0000, 16'h0313), '0, '0, '0,
                       1, 16'h0C00, 4'b0001, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h0300));
        vecs[9]  = mkv(0, 4'b0001, '0, '0, '0, rq(0, 16'h0000, 16'h0310),
                       2, 16'h0C13, 4'b1000, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h0313));
        vecs[10] = mkv(0, 4'b1000, rq(0, 16'h0000, 16'h0323), '0, '0, '0,
                       1, 16'h0C10, 4'b0001, 4'b0000, 16'h0000, rq(0, 16'h0000, 16'h0310));

        reset               = 1'b0;
        cache_request       = '0;
        cache_request_ready = '0;
        mem_response        = '0;
        mem_response_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs",
            {busy, mem_request_ready, mem_request, cache_response, cache_response_ready,
             invalidate_address, invalidate_valid}, 64'd0);
        reset = 1'b1;

        for (int v = 0; v < NUM_V; v++) begin
            t = vecs[v];
            if (t.do_reset) begin
                reset = 1'b0;
                @(posedge clock);
                #1;
                chk("reset_busy", {busy, mem_request_ready, cache_response}, 64'd0);
                reset = 1'b1;
            end
            for (int c = 0; c < 4; c++) begin
                if (t.set_ready[c]) begin
                    cache_request[c*33 +: 33] = t.reqs[c];
                    cache_request_ready[c]    = 1'b1;
                end
            end

            n = 0;
            while (n < 8) begin
                @(posedge clock);
                #1;
                n++;
                if (mem_request_ready) break;
            end
            chk("grant_latency", 64'(n), 64'd1);
            chk("mem_request", mem_request, t.exp_mem_req);
            chk("busy_wait", busy, 1'b1);

            g = 0;
            for (int c = 0; c < 4; c++) if (t.exp_resp_ready[c]) g = c;
            cache_request[g*33 +: 33] = ~t.exp_mem_req;

            for (int c = 0; c < t.lat; c++) begin
                @(posedge clock);
                #1;
                chk("mem_request_hold", {mem_request_ready, mem_request}, {1'b1, t.exp_mem_req});
            end

            mem_response       = t.rsp;
            mem_response_ready = 1'b1;
            @(posedge clock);
            #1;
            mem_response_ready = 1'b0;
            mem_response       = 16'($urandom);
            chk("cache_response", cache_response, t.rsp);
            chk("cache_response_ready", cache_response_ready, t.exp_resp_ready);
            chk("invalidate_valid", invalidate_valid, t.exp_inv_valid);
            chk("invalidate_address", invalidate_address, t.exp_inv_addr);
            chk("mem_idle_respond", {mem_request_ready, mem_request}, 64'd0);
            cache_request_ready[g] = 1'b0;

            @(posedge clock);
            #1;
            chk("drain_strobes", {cache_response_ready, invalidate_valid, mem_request_ready}, 64'd0);
            chk("drain_hold", {busy, cache_response}, {1'b1, t.rsp});
            mem_response       = 16'hDEAD;
            mem_response_ready = 1'b1;

            @(posedge clock);
            #1;
            mem_response_ready = 1'b0;
            chk("idle_after_drain", {busy, cache_response_ready}, 64'd0);
            chk("response_held", cache_response, t.rsp);

            $display("txn %0d: grant=%0d mem_req=%h rsp=%h inv=%b resp_ready=%b",
                     v, g, t.exp_mem_req, cache_response, t.exp_inv_valid, t.exp_resp_ready);
        end

        // Reset in the middle of WAIT, followed by a late memory response.
        cache_request_ready = '0;
        cache_request[1*33 +: 33] = rq(0, 16'h0000, 16'h0777);
        cache_request_ready[1]    = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_grant", {mem_request_ready, mem_request}, {1'b1, rq(0, 16'h0000, 16'h0777)});
        @(posedge clock);
        #1;
        reset               = 1'b0;
        cache_request_ready = '0;
        @(posedge clock);
        #1;
        reset              = 1'b1;
        mem_response       = 16'h1111;
        mem_response_ready = 1'b1;
        chk("abort_outputs",
            {busy, mem_request_ready, mem_request, cache_response, cache_response_ready,
             invalidate_valid}, 64'd0);
        @(posedge clock);
        #1;
        mem_response_ready = 1'b0;
        chk("abort_late_response", {busy, cache_response_ready, cache_response, invalidate_valid}, 64'd0);
        @(posedge clock);
        #1;
        chk("abort_still_idle", {busy, cache_response_ready, mem_request_ready}, 64'd0);
        $display("txn abort: reset during WAIT, late response ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
